// File: rtl/sprite_scan_pkg.sv
// ============================================================================
//  Module : sprite_scan_pkg
//  Desc   : Shared types and defaults for the sprite scan counter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sprite_scan_pkg;

    localparam int DEFAULT_XW = 5;
    localparam int DEFAULT_YW = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/sprite_scan_ctr_axis_ctr.sv
// ============================================================================
//  Module : axis_ctr
//  Desc   : Single-axis wrap counter against a runtime limit.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_ctr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign at_max = (count_q == limit);
    assign count  = count_q;

    // Wrapping to zero at the limit leaves the counter ready for the next sprite.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = at_max ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sprite_scan_ctr.sv
// ============================================================================
//  Module : sprite_scan_ctr
//  Desc   : Runtime-sized 2D sprite scan with flips and valid/ready output.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_scan_ctr
    import sprite_scan_pkg::*;
#(
    parameter int XW = DEFAULT_XW,
    parameter int YW = DEFAULT_YW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XW-1:0]   req_dim_x,
    input  logic [YW-1:0]   req_dim_y,
    input  logic            req_flip_x,
    input  logic            req_flip_y,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic [XW-1:0]   pix_x,
    output logic [YW-1:0]   pix_y,
    output logic [XW+YW-1:0] pix_idx,
    output logic            pix_eol,
    output logic            pix_last,
    output logic            busy
);

    localparam int IW = XW + YW;

    scan_state_e   state_q,  state_d;
    logic [XW-1:0] dim_x_q,  dim_x_d;
    logic [YW-1:0] dim_y_q,  dim_y_d;
    logic          flip_x_q, flip_x_d;
    logic          flip_y_q, flip_y_d;
    logic [IW-1:0] idx_q,    idx_d;

    logic          scanning;
    logic          accept;
    logic          beat;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          x_at_max;
    logic          y_at_max;
    logic          last_beat;

    assign scanning  = (state_q == ST_SCAN);
    assign accept    = !scanning && req_valid;
    assign beat      = scanning && pix_ready;
    assign last_beat = x_at_max && y_at_max;

    axis_ctr #(.W(XW)) u_x_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (beat),
        .limit  (dim_x_q),
        .count  (cx),
        .at_max (x_at_max)
    );

    axis_ctr #(.W(YW)) u_y_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (beat && x_at_max),
        .limit  (dim_y_q),
        .count  (cy),
        .at_max (y_at_max)
    );

    always_comb begin
        state_d  = state_q;
        dim_x_d  = dim_x_q;
        dim_y_d  = dim_y_q;
        flip_x_d = flip_x_q;
        flip_y_d = flip_y_q;
        idx_d    = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_SCAN;
                    dim_x_d  = req_dim_x;
                    dim_y_d  = req_dim_y;
                    flip_x_d = req_flip_x;
                    flip_y_d = req_flip_y;
                    idx_d    = '0;
                end
            end
            ST_SCAN: begin
                if (beat) begin
                    idx_d = idx_q + IW'(1);
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dim_x_q  <= '0;
            dim_y_q  <= '0;
            flip_x_q <= 1'b0;
            flip_y_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            dim_x_q  <= dim_x_d;
            dim_y_q  <= dim_y_d;
            flip_x_q <= flip_x_d;
            flip_y_q <= flip_y_d;
            idx_q    <= idx_d;
        end
    end

    // Outputs decode registered state only; idle forces coordinates to zero.
    assign req_ready = !scanning;
    assign pix_valid = scanning;
    assign busy      = scanning;
    assign pix_x     = !scanning ? '0 : (flip_x_q ? dim_x_q - cx : cx);
    assign pix_y     = !scanning ? '0 : (flip_y_q ? dim_y_q - cy : cy);
    assign pix_idx   = scanning ? idx_q : '0;
    assign pix_eol   = scanning && x_at_max;
    assign pix_last  = scanning && last_beat;

endmodule

`default_nettype wire

// File: tb/tb_sprite_scan_ctr.sv
// ============================================================================
//  Module : tb_sprite_scan_ctr
//  Desc   : Randomised bench for sprite_scan_ctr against a row-major beat list.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sprite_scan_ctr;

    localparam int XW = 5;
    localparam int YW = 5;
    localparam int IW = XW + YW;

    typedef struct {
        int x;
        int y;
        int idx;
        int eol;
        int last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [XW-1:0]   req_dim_x;
    logic [YW-1:0]   req_dim_y;
    logic            req_flip_x;
    logic            req_flip_y;
    logic            pix_valid;
    logic            pix_ready;
    logic [XW-1:0]   pix_x;
    logic [YW-1:0]   pix_y;
    logic [IW-1:0]   pix_idx;
    logic            pix_eol;
    logic            pix_last;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sprite_scan_ctr #(.XW(XW), .YW(YW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dim_x  (req_dim_x),
        .req_dim_y  (req_dim_y),
        .req_flip_x (req_flip_x),
        .req_flip_y (req_flip_y),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_idx    (pix_idx),
        .pix_eol    (pix_eol),
        .pix_last   (pix_last),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected beats: row-major scan of the sprite with flips applied to coordinates.
    function automatic void build_expect(input int dx, input int dy, input bit fx,
                                         input bit fy, ref beat_t q[$]);
        int k = 0;
        q.delete();
        for (int y = 0; y <= dy; y++) begin
            for (int x = 0; x <= dx; x++) begin
                beat_t b;
                b.x    = fx ? dx - x : x;
                b.y    = fy ? dy - y : y;
                b.idx  = k;
                b.eol  = (x == dx);
                b.last = (x == dx) && (y == dy);
                q.push_back(b);
                k++;
            end
        end
    endfunction

    function automatic logic [IW+IW+1:0] snap();
        return {pix_x, pix_y, pix_idx, pix_eol, pix_last};
    endfunction

    task automatic idle_checks(input string tag);
        check_eq({tag, "_valid"}, pix_valid, 0);
        check_eq({tag, "_ready"}, req_ready, 1);
        check_eq({tag, "_busy"},  busy, 0);
    endtask

    // Called at a negedge; returns at the negedge after the scan should be over.
    task automatic run_sprite(input int dx, input int dy, input bit fx, input bit fy,
                              input bit rnd_ready, input bit noise);
        beat_t q[$];
        logic [IW+IW+1:0] prev;
        bit   held = 0;
        int   budget;
        build_expect(dx, dy, fx, fy, q);
        budget = 4 * q.size() + 20;
        check_eq("pre_req_ready", req_ready, 1);
        req_valid  = 1'b1;
        req_dim_x  = XW'(dx);
        req_dim_y  = YW'(dy);
        req_flip_x = fx;
        req_flip_y = fy;
        @(negedge clk);
        req_valid = 1'b0;
        while (q.size() != 0 && budget > 0) begin
            budget--;
            check_eq("scan_valid", pix_valid, 1);
            check_eq("scan_req_ready", req_ready, 0);
            if (held) check_eq("stable_hold", snap(), prev);
            pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                req_valid  = 1'($urandom_range(0, 1));
                req_dim_x  = XW'($urandom);
                req_dim_y  = YW'($urandom);
                req_flip_x = 1'($urandom);
                req_flip_y = 1'($urandom);
            end
            if (pix_valid && pix_ready) begin
                beat_t e = q.pop_front();
                check_eq("pix_x",    pix_x,    e.x);
                check_eq("pix_y",    pix_y,    e.y);
                check_eq("pix_idx",  pix_idx,  e.idx);
                check_eq("pix_eol",  pix_eol,  e.eol);
                check_eq("pix_last", pix_last, e.last);
                held = 0;
            end else begin
                held = pix_valid;
                prev = snap();
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        pix_ready = 1'b1;
        check_eq("beats_remaining", q.size(), 0);
        idle_checks("post_scan");
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_dim_x  = '0;
        req_dim_y  = '0;
        req_flip_x = 1'b0;
        req_flip_y = 1'b0;
        pix_ready  = 1'b1;
        repeat (2) @(negedge clk);
        idle_checks("reset");
        check_eq("reset_x",   pix_x,   0);
        check_eq("reset_idx", pix_idx, 0);
        rst = 1'b0;
        @(negedge clk);

        run_sprite(3, 2, 0, 0, 0, 0);
        @(negedge clk);
        run_sprite(3, 2, 1, 1, 0, 0);
        run_sprite(0, 0, 0, 0, 0, 0);
        run_sprite(31, 31, 0, 0, 0, 0);
        run_sprite(3, 2, 0, 0, 1, 1);
        run_sprite(3, 2, 1, 0, 1, 1);

        for (int i = 0; i < 8; i++) begin
            run_sprite($urandom_range(0, 7), $urandom_range(0, 5),
                       1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Mid-scan reset while beat idx 5 is presented and stalled.
        req_valid = 1'b1;
        req_dim_x = XW'(3);
        req_dim_y = YW'(2);
        req_flip_x = 1'b1;
        req_flip_y = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        pix_ready = 1'b1;
        begin
            int guard = 0;
            while (!(pix_valid && pix_idx == IW'(5)) && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check_eq("reach_idx5", guard < 20, 1);
        end
        pix_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pix_ready = 1'b1;
        idle_checks("midrst");
        check_eq("midrst_x",    pix_x,    0);
        check_eq("midrst_y",    pix_y,    0);
        check_eq("midrst_idx",  pix_idx,  0);
        check_eq("midrst_eol",  pix_eol,  0);
        check_eq("midrst_last", pix_last, 0);
        run_sprite(1, 1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
